// File: rtl/wddl_ctrl_pkg.sv
// Shared types and constants for the WDDL five-operand XOR controller.
// Holds the state encoding, the dual-rail word payload and the encoding check.
package wddl_ctrl_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned NUM_OPS = 5;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned PHASE_W = 4;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_PRECH = 2'd1,
        ST_EVAL  = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    typedef struct packed {
        logic [WORD_W-1:0] p;
        logic [WORD_W-1:0] n;
    } dr_word_t;

    typedef dr_word_t [NUM_OPS-1:0] dr_ops_t;

    // A well-formed dual-rail word has exactly one rail high on every bit.
    function automatic logic dr_bad(input dr_word_t w);
        return (w.p ^ w.n) != '1;
    endfunction

endpackage

// File: rtl/wddl_xor5_32.sv
// Combinational dual-rail XOR of five 32-bit operands built from WDDL XOR gates.
// An all-zero (precharge) operand set yields an all-zero result on both rails.
module wddl_xor5_32
    import wddl_ctrl_pkg::*;
(
    input  dr_ops_t  ops,
    output dr_word_t res
);

    // Positive-only WDDL XOR: both rails are AND-OR networks, so no glitchy inversion.
    function automatic dr_word_t dr_xor(input dr_word_t a, input dr_word_t b);
        dr_word_t r;
        r.p = (a.p & b.n) | (a.n & b.p);
        r.n = (a.p & b.p) | (a.n & b.n);
        return r;
    endfunction

    always_comb begin
        res = ops[0];
        for (int i = 1; i < int'(NUM_OPS); i++) begin
            res = dr_xor(res, ops[i]);
        end
    end

endmodule

// File: rtl/wddl_xor5_ctrl.sv
// Controller collecting five dual-rail operand words, running a precharge/evaluate
// sequence through the WDDL XOR datapath and presenting the result with a handshake.
module wddl_xor5_ctrl
    import wddl_ctrl_pkg::*;
#(
    parameter int unsigned PRECH_CYCLES = 1,
    parameter int unsigned EVAL_CYCLES  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_p_in,
    input  logic [WORD_W-1:0] in_n_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] d_p_out,
    output logic [WORD_W-1:0] d_n_out,
    output logic              busy,
    output logic              err,
    input  logic              err_clr
);

    localparam logic [PHASE_W-1:0] PRECH_LAST = PHASE_W'(PRECH_CYCLES - 1);
    localparam logic [PHASE_W-1:0] EVAL_LAST  = PHASE_W'(EVAL_CYCLES - 1);
    localparam logic [CNT_W-1:0]   LAST_OP    = CNT_W'(NUM_OPS - 1);

    state_t             state, state_d;
    logic [CNT_W-1:0]   count, count_d;
    logic [PHASE_W-1:0] phase, phase_d;

    dr_ops_t  ops;
    dr_ops_t  g_ops;
    dr_word_t in_word;
    dr_word_t res;

    logic eval_en;
    logic accept;
    logic capture;
    logic release_out;
    logic new_err;
    logic in_ready_d, busy_d, out_valid_d, eval_en_d;

    assign in_word     = '{p: in_p_in, n: in_n_in};
    assign accept      = in_valid && in_ready;
    assign capture     = (state == ST_EVAL) && (phase == EVAL_LAST);
    assign release_out = (state == ST_OUT) && out_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_LOAD;
            count <= '0;
            phase <= '0;
        end else begin
            state <= state_d;
            count <= count_d;
            phase <= phase_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        count_d = count;
        phase_d = phase;
        case (state)
            ST_LOAD: begin
                if (accept) begin
                    if (count == LAST_OP) begin
                        state_d = ST_PRECH;
                        count_d = '0;
                        phase_d = '0;
                    end else begin
                        count_d = count + CNT_W'(1);
                    end
                end
            end
            ST_PRECH: begin
                if (phase == PRECH_LAST) begin
                    state_d = ST_EVAL;
                    phase_d = '0;
                end else begin
                    phase_d = phase + PHASE_W'(1);
                end
            end
            ST_EVAL: begin
                if (capture) begin
                    state_d = ST_OUT;
                    phase_d = '0;
                end else begin
                    phase_d = phase + PHASE_W'(1);
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    // Output decode from the next state, so the flags below are registered
    always_comb begin
        in_ready_d  = 1'b0;
        busy_d      = 1'b0;
        out_valid_d = 1'b0;
        eval_en_d   = 1'b0;
        in_ready_d  = (state_d == ST_LOAD);
        busy_d      = (state_d != ST_LOAD) || (count_d != '0);
        out_valid_d = (state_d == ST_OUT);
        eval_en_d   = (state_d == ST_EVAL);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            eval_en   <= 1'b0;
        end else begin
            in_ready  <= in_ready_d;
            busy      <= busy_d;
            out_valid <= out_valid_d;
            eval_en   <= eval_en_d;
        end
    end

    // Operand capture in arrival order
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ops <= '0;
        end else if (accept) begin
            for (int i = 0; i < int'(NUM_OPS); i++) begin
                if (count == CNT_W'(i)) begin
                    ops[i] <= in_word;
                end
            end
        end
    end

    // Rails stay in precharge (all zero) except while evaluating
    assign g_ops = eval_en ? ops : '0;

    wddl_xor5_32 u_xor (
        .ops (g_ops),
        .res (res)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d_p_out <= '0;
            d_n_out <= '0;
        end else if (capture) begin
            d_p_out <= res.p;
            d_n_out <= res.n;
        end else if (release_out) begin
            d_p_out <= '0;
            d_n_out <= '0;
        end
    end

    // Sticky error; a fresh error outranks a simultaneous clear
    assign new_err = (accept && dr_bad(in_word)) || (capture && dr_bad(res));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else begin
            err <= new_err || (err && !err_clr);
        end
    end

endmodule

// File: tb/tb_wddl_xor5_ctrl.sv
// Scoreboard bench for wddl_xor5_ctrl: one instance with default phase lengths,
// one with PRECH_CYCLES=3 / EVAL_CYCLES=2, driven one at a time.
module tb_wddl_xor5_ctrl;
    import wddl_ctrl_pkg::*;

    localparam int P0 = 1, E0 = 1, P1 = 3, E1 = 2;

    typedef struct {
        int          inst;
        logic [31:0] p;
        logic [31:0] n;
        int          due;
        bit          chk;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic        in_valid [2];
    logic        in_ready [2];
    logic        out_valid[2];
    logic        out_ready[2];
    logic        busy     [2];
    logic        err      [2];
    logic        err_clr  [2];
    logic [31:0] in_p     [2];
    logic [31:0] in_n     [2];
    logic [31:0] d_p      [2];
    logic [31:0] d_n      [2];

    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    exp_t q[$];
    int   ev_lo[2];
    int   ev_hi[2];
    bit   err_m[2];
    logic prev_v[2] = '{1'b0, 1'b0};

    wddl_xor5_ctrl #(.PRECH_CYCLES(P0), .EVAL_CYCLES(E0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_p_in(in_p[0]), .in_n_in(in_n[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .d_p_out(d_p[0]), .d_n_out(d_n[0]),
        .busy(busy[0]), .err(err[0]), .err_clr(err_clr[0])
    );

    wddl_xor5_ctrl #(.PRECH_CYCLES(P1), .EVAL_CYCLES(E1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_p_in(in_p[1]), .in_n_in(in_n[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .d_p_out(d_p[1]), .d_n_out(d_n[1]),
        .busy(busy[1]), .err(err[1]), .err_clr(err_clr[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic failc(input string name, input string what);
        n_chk++;
        n_err++;
        $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
    endtask

    function automatic int lat(input int i);
        return (i == 0) ? (P0 + E0) : (P1 + E1);
    endfunction

    function automatic int prech(input int i);
        return (i == 0) ? P0 : P1;
    endfunction

    // Monitor: results against the scoreboard, precharge on the datapath inputs
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            dr_ops_t g;
            if (!rst_n) begin
                prev_v[i] = 1'b0;
                continue;
            end
            g = (i == 0) ? dut0.g_ops : dut1.g_ops;
            if (!(cyc >= ev_lo[i] && cyc <= ev_hi[i]))
                chk($sformatf("precharge_zero%0d", i), 64'(g != '0), 64'd0);
            if (out_valid[i]) begin
                chk($sformatf("in_ready_in_out%0d", i), 64'(in_ready[i]), 64'd0);
                if (q.size() == 0) begin
                    failc($sformatf("unexpected_result%0d", i), "got out_valid=1, required no pending result");
                end else begin
                    chk($sformatf("result_inst%0d", i), 64'(i), 64'(q[0].inst));
                    if (!prev_v[i])
                        chk($sformatf("latency%0d", i), 64'(cyc), 64'(q[0].due));
                    if (q[0].chk) begin
                        chk($sformatf("d_p_out%0d", i), 64'(d_p[i]), 64'(q[0].p));
                        chk($sformatf("d_n_out%0d", i), 64'(d_n[i]), 64'(q[0].n));
                    end
                    if (out_ready[i]) void'(q.pop_front());
                end
            end else begin
                chk($sformatf("idle_rails%0d", i), {d_p[i], d_n[i]}, 64'd0);
            end
            prev_v[i] = out_valid[i];
        end
    end

    task automatic check_idle(input int i, input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready[i]), 64'd1);
        chk({tag, "_out_valid"}, 64'(out_valid[i]), 64'd0);
        chk({tag, "_rails"}, {d_p[i], d_n[i]}, 64'd0);
        chk({tag, "_busy"}, 64'(busy[i]), 64'd0);
        chk({tag, "_err"}, 64'(err[i]), 64'(err_m[i]));
    endtask

    // Offers nw words; with nw==5 also pushes the expectation and completes the handshake
    task automatic send_batch(input int i, input logic [31:0] wp[5], input logic [31:0] wn[5],
                              input int nw, input int bp, input int clr_at);
        logic [31:0] xp;
        bit ok, bad, rdy;
        int held, acc_cyc;
        exp_t e;
        xp = '0;
        bad = 1'b0;
        acc_cyc = 0;
        for (int w = 0; w < nw; w++) begin
            repeat ($urandom_range(0, 2)) begin
                in_valid[i] = 1'b0;
                @(posedge clk); #1;
            end
            ok = 1'b0;
            for (int t = 0; t < 50 && !ok; t++) begin
                rdy = in_ready[i];
                in_valid[i] = 1'b1;
                in_p[i] = wp[w];
                in_n[i] = wn[w];
                err_clr[i] = (w == clr_at) && rdy;
                @(posedge clk); #1;
                err_clr[i] = 1'b0;
                ok = rdy;
            end
            if (!ok) begin
                in_valid[i] = 1'b0;
                failc("accept_timeout", "got no accept, required one within 50 cycles");
                return;
            end
            acc_cyc = cyc;
            if ((wp[w] ^ wn[w]) != 32'hFFFFFFFF) begin
                err_m[i] = 1'b1;
                bad = 1'b1;
            end else if (w == clr_at) begin
                err_m[i] = 1'b0;
            end
            xp ^= wp[w];
            chk("err_after_accept", 64'(err[i]), 64'(err_m[i]));
            chk("busy_after_accept", 64'(busy[i]), 64'd1);
        end
        in_valid[i] = 1'b0;
        if (nw < 5) return;

        e.inst = i;
        e.p = xp;
        e.n = ~xp;
        e.due = acc_cyc + lat(i);
        e.chk = !bad;
        q.push_back(e);
        ev_lo[i] = acc_cyc + prech(i);
        ev_hi[i] = acc_cyc + lat(i) - 1;

        // Junk offered while busy must be ignored, including on the handshake edge
        held = 0;
        ok = 1'b0;
        for (int t = 0; t < 200 && !ok; t++) begin
            in_valid[i] = 1'b1;
            in_p[i] = $urandom;
            in_n[i] = $urandom;
            if (out_valid[i]) begin
                if (held < bp) begin
                    out_ready[i] = 1'b0;
                    held++;
                end else begin
                    out_ready[i] = 1'b1;
                    ok = 1'b1;
                end
            end else begin
                out_ready[i] = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
        end
        in_valid[i] = 1'b0;
        out_ready[i] = 1'b0;
        if (!ok) failc("result_timeout", "got no out_valid, required one within 200 cycles");
        else check_idle(i, "after_handshake");
    endtask

    task automatic pulse_clr(input int i);
        err_clr[i] = 1'b1;
        @(posedge clk); #1;
        err_clr[i] = 1'b0;
        err_m[i] = 1'b0;
        chk("err_cleared", 64'(err[i]), 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, required completion before 400000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] wp[5];
        logic [31:0] wn[5];
        int inst;
        for (int i = 0; i < 2; i++) begin
            in_valid[i] = 1'b0; out_ready[i] = 1'b0; err_clr[i] = 1'b0;
            in_p[i] = '0; in_n[i] = '0;
            ev_lo[i] = -100; ev_hi[i] = -100; err_m[i] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check_idle(0, "reset0");
        check_idle(1, "reset1");

        // Base case: one-hot words, consumer always ready
        for (int w = 0; w < 5; w++) begin
            wp[w] = 32'h1 << w;
            wn[w] = ~wp[w];
        end
        send_batch(0, wp, wn, 5, 0, -1);

        // Backpressure for three cycles
        for (int w = 0; w < 5; w++) begin
            wp[w] = $urandom;
            wn[w] = ~wp[w];
        end
        send_batch(0, wp, wn, 5, 3, -1);

        // Malformed second word still produces a result, then clear
        for (int w = 0; w < 5; w++) begin
            wp[w] = $urandom;
            wn[w] = ~wp[w];
        end
        wp[1] = 32'h1;
        wn[1] = 32'h1;
        send_batch(0, wp, wn, 5, 1, -1);
        pulse_clr(0);

        // Reset after three words discards them
        for (int w = 0; w < 5; w++) begin
            wp[w] = $urandom;
            wn[w] = ~wp[w];
        end
        send_batch(0, wp, wn, 3, 0, -1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        err_m[0] = 1'b0;
        err_m[1] = 1'b0;
        check_idle(0, "reset_mid_load");
        for (int w = 0; w < 5; w++) begin
            wp[w] = 32'hA5A5A5A5;
            wn[w] = 32'h5A5A5A5A;
        end
        send_batch(0, wp, wn, 5, 0, -1);

        // Longer phases: latency 5, precharge watched by the monitor
        for (int b = 0; b < 3; b++) begin
            for (int w = 0; w < 5; w++) begin
                wp[w] = $urandom;
                wn[w] = ~wp[w];
            end
            send_batch(1, wp, wn, 5, b, -1);
        end

        // Clear coinciding with a malformed accept: set wins
        for (int w = 0; w < 5; w++) begin
            wp[w] = $urandom;
            wn[w] = ~wp[w];
        end
        wp[2] = 32'h0;
        wn[2] = 32'h0;
        send_batch(1, wp, wn, 5, 0, 2);
        pulse_clr(1);

        // Random traffic on both instances
        for (int b = 0; b < 16; b++) begin
            inst = int'($urandom_range(0, 1));
            for (int w = 0; w < 5; w++) begin
                wp[w] = $urandom;
                wn[w] = ~wp[w];
            end
            send_batch(inst, wp, wn, 5, int'($urandom_range(0, 3)), -1);
        end

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
